// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and load scoreboard sharing the register file write port.
// Optional operand forwarding from the registered write: define WB_FWD_EN.
module regfile_wb_arbiter #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [WIDTH-1:0]  alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [WIDTH-1:0]  mem_data,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              hazard,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [WIDTH-1:0]  rf_wdata
`ifdef WB_FWD_EN
  ,
  input  logic [WIDTH-1:0]  rf_rd1,
  input  logic [WIDTH-1:0]  rf_rd2,
  output logic [WIDTH-1:0]  fwd_rd1,
  output logic [WIDTH-1:0]  fwd_rd2
`endif
);
  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0]   busy_q, busy_d;
  logic              pref_mem_q;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [WIDTH-1:0]  rf_wdata_q;

  logic              alu_req, alu_gnt, mem_gnt;
  logic [ADDR_W-1:0] wr_rd;
  logic [WIDTH-1:0]  wr_data;

  // ALU may not overtake an outstanding load to the same register (WAW)
  always_comb begin
    alu_req = alu_valid && !(busy_q[alu_rd] && alu_rd != '0);
    mem_gnt = rst && mem_valid && (!alu_req || pref_mem_q);
    alu_gnt = rst && alu_req && (!mem_valid || !pref_mem_q);
    wr_rd   = mem_gnt ? mem_rd : alu_rd;
    wr_data = mem_gnt ? mem_data : alu_data;
  end

  assign alu_ready = alu_gnt;
  assign mem_ready = mem_gnt;

  // Set applied after clear so a reissued load to the same rd stays busy
  always_comb begin
    busy_d = busy_q;
    if (mem_gnt) busy_d[mem_rd] = 1'b0;
    if (ld_issue) busy_d[ld_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      pref_mem_q <= 1'b1;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      busy_q <= busy_d;
      if (alu_gnt || mem_gnt) begin
        pref_mem_q <= alu_gnt;
        rf_we_q    <= (wr_rd != '0);
        rf_waddr_q <= wr_rd;
        rf_wdata_q <= wr_data;
      end else begin
        rf_we_q <= 1'b0;
      end
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  logic src_busy;
  assign src_busy = (rs1 != '0 && busy_q[rs1]) || (rs2 != '0 && busy_q[rs2]);

`ifdef WB_FWD_EN
  assign fwd_rd1 = (rf_we_q && rf_waddr_q == rs1 && rs1 != '0) ? rf_wdata_q : rf_rd1;
  assign fwd_rd2 = (rf_we_q && rf_waddr_q == rs2 && rs2 != '0) ? rf_wdata_q : rf_rd2;
  assign hazard  = src_busy;
`else
  // Without forwarding, decode must wait out the registered write as well
  assign hazard = src_busy ||
                  (rf_we_q && rf_waddr_q != '0 && (rf_waddr_q == rs1 || rf_waddr_q == rs2));
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed test-plan items then randomized traffic,
// all checked against a behavioural model of grants, scoreboard and write port.
module tb_regfile_wb_arbiter;
  localparam int WIDTH = 32, ADDR_W = 5;

  logic clk = 1'b0, rst = 1'b0;
  logic alu_valid = 0, mem_valid = 0, ld_issue = 0;
  logic alu_ready, mem_ready, hazard, rf_we;
  logic [ADDR_W-1:0] alu_rd = 0, mem_rd = 0, ld_rd = 0, rs1 = 0, rs2 = 0, rf_waddr;
  logic [WIDTH-1:0]  alu_data = 0, mem_data = 0, rf_wdata;
`ifdef WB_FWD_EN
  logic [WIDTH-1:0]  rf_rd1 = 0, rf_rd2 = 0, fwd_rd1, fwd_rd2;
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .ld_issue(ld_issue), .ld_rd(ld_rd), .rs1(rs1), .rs2(rs2), .hazard(hazard),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef WB_FWD_EN
    , .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .fwd_rd1(fwd_rd1), .fwd_rd2(fwd_rd2)
`endif
  );

  int n_cmp = 0, n_err = 0;

  // Model state: which registers await a load, who won last, pending RF write
  bit          m_busy [32];
  int          m_last;          // 1 = mem, 2 = alu
  bit          m_we;
  int unsigned m_waddr, m_wdata;

  // Values sampled mid-cycle by cyc(), for literal checks by the caller
  logic s_alu_ready, s_mem_ready, s_hazard, s_we;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 0;
    m_last = 2; m_we = 0; m_waddr = 0; m_wdata = 0;
  endtask

  // One cycle: called at negedge with inputs applied; compares, then advances model at posedge.
  task automatic cyc();
    int  gnt;
    bit  a_ok, hz;
    #1;
    if (!rst) model_reset();
    a_ok = alu_valid && !(alu_rd != 0 && m_busy[alu_rd]);
    gnt = 0;
    if (rst) begin
      if (a_ok && mem_valid) gnt = (m_last == 2) ? 1 : 2;
      else if (a_ok)         gnt = 2;
      else if (mem_valid)    gnt = 1;
    end
    hz = (rs1 != 0 && m_busy[rs1]) || (rs2 != 0 && m_busy[rs2]);
`ifndef WB_FWD_EN
    if (m_we && m_waddr != 0 && (m_waddr == rs1 || m_waddr == rs2)) hz = 1;
`endif
    s_alu_ready = alu_ready; s_mem_ready = mem_ready; s_hazard = hazard; s_we = rf_we;
    chk("alu_ready", alu_ready, gnt == 2);
    chk("mem_ready", mem_ready, gnt == 1);
    chk("hazard", hazard, hz);
    chk("rf_we", rf_we, m_we);
    if (m_we) begin
      chk("rf_waddr", rf_waddr, m_waddr);
      chk("rf_wdata", rf_wdata, m_wdata);
    end
`ifdef WB_FWD_EN
    chk("fwd_rd1", fwd_rd1, (m_we && m_waddr == rs1 && rs1 != 0) ? m_wdata : rf_rd1);
    chk("fwd_rd2", fwd_rd2, (m_we && m_waddr == rs2 && rs2 != 0) ? m_wdata : rf_rd2);
`endif
    @(posedge clk);
    if (rst) begin
      m_we = 0;
      if (gnt != 0) begin
        m_last  = gnt;
        m_waddr = (gnt == 1) ? mem_rd : alu_rd;
        m_wdata = (gnt == 1) ? mem_data : alu_data;
        m_we    = (m_waddr != 0);
        if (gnt == 1) m_busy[mem_rd] = 0;
      end
      if (ld_issue && ld_rd != 0) m_busy[ld_rd] = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    alu_valid = 0; mem_valid = 0; ld_issue = 0; rs1 = 0; rs2 = 0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    // Reset held with both requesters valid
    alu_valid = 1; alu_rd = 3; alu_data = 32'hA3;
    mem_valid = 1; mem_rd = 4; mem_data = 32'hB4;
    cyc();
    chk("rst_alu_ready", s_alu_ready, 0);
    chk("rst_mem_ready", s_mem_ready, 0);
    chk("rst_rf_we", s_we, 0);
    chk("rst_hazard", s_hazard, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);

    // Release: strict alternation starting with mem
    rst = 1;
    cyc(); chk("alt0_mem", s_mem_ready, 1); chk("alt0_waddr", rf_waddr, 4);
    cyc(); chk("alt1_alu", s_alu_ready, 1); chk("alt1_waddr", rf_waddr, 3);
    cyc(); chk("alt2_mem", s_mem_ready, 1); chk("alt2_waddr", rf_waddr, 4);
    cyc(); chk("alt3_alu", s_alu_ready, 1); chk("alt3_waddr", rf_waddr, 3);

    // ALU alone
    idle(); alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    cyc();
    chk("alu5_ready", s_alu_ready, 1);
    chk("alu5_we", rf_we, 1); chk("alu5_waddr", rf_waddr, 5); chk("alu5_wdata", rf_wdata, 32'hDEADBEEF);

    // Load to x7, RAW hazard and WAW block until return
    idle(); ld_issue = 1; ld_rd = 7; rs1 = 7;
    cyc();
    ld_issue = 0; alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    cyc();
    chk("ld7_hazard", s_hazard, 1); chk("ld7_alu_blocked", s_alu_ready, 0);
    mem_valid = 1; mem_rd = 7; mem_data = 32'h1234;
    cyc();
    chk("ld7_mem_ready", s_mem_ready, 1); chk("ld7_alu_still", s_alu_ready, 0);
    mem_valid = 0; rs1 = 0;
    cyc();
    chk("ld7_alu_after", s_alu_ready, 1);

    // Set and clear of x9 on the same edge: set wins
    idle(); ld_issue = 1; ld_rd = 9;
    cyc();
    mem_valid = 1; mem_rd = 9; mem_data = 32'h99;
    cyc();
    idle(); alu_valid = 1; alu_rd = 9; alu_data = 32'h9;
    cyc();
    chk("x9_busy_kept", s_alu_ready, 0);
    alu_rd = 0; alu_data = 32'h1;
    cyc();
    chk("x0_ready", s_alu_ready, 1); chk("x0_no_we", rf_we, 0);
    // Drain x9
    idle(); mem_valid = 1; mem_rd = 9;
    cyc();

    // Pending write to x2 seen by decode
    idle(); alu_valid = 1; alu_rd = 2; alu_data = 32'h55;
    cyc();
    idle(); rs2 = 2;
`ifdef WB_FWD_EN
    rf_rd2 = 32'h0BAD;
    cyc();
    chk("fwd_hazard", s_hazard, 0);
    chk("fwd_rd2_val", fwd_rd2, 32'h0BAD);
`else
    cyc();
    chk("nofwd_hazard", s_hazard, 1);
`endif

    // Randomized traffic with occasional asynchronous reset
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 0; idle(); alu_valid = 1; mem_valid = 1;
        cyc();
        rst = 1;
      end
      alu_valid = ($urandom_range(0, 3) != 0);
      alu_rd    = ADDR_W'($urandom_range(0, 7));
      alu_data  = $urandom;
      mem_valid = ($urandom_range(0, 2) == 0);
      mem_rd    = ADDR_W'($urandom_range(0, 7));
      mem_data  = $urandom;
      ld_issue  = ($urandom_range(0, 3) == 0);
      ld_rd     = ADDR_W'($urandom_range(0, 7));
      rs1       = ADDR_W'($urandom_range(0, 7));
      rs2       = ADDR_W'($urandom_range(0, 7));
`ifdef WB_FWD_EN
      rf_rd1 = $urandom; rf_rd2 = $urandom;
`endif
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
